// File: rtl/red_pitaya_daisy_framer.sv
// Frames a 16-bit sample stream into header/payload/trailer words for the daisy TX port.
// Build option DAISY_FRAMER_CRC_EN selects a CRC-16-CCITT trailer instead of the modulo sum.
module red_pitaya_daisy_framer #(
  parameter int unsigned FIFO_AW = 9,
  parameter logic [7:0]  HDR_TAG = 8'hA5
) (
  input  logic               par_clk_i,
  input  logic               par_rstn_i,
  input  logic               cfg_en_i,
  input  logic [7:0]         cfg_len_i,
  input  logic               stat_clr_i,
  input  logic [15:0]        dat_i,
  input  logic               dv_i,
  input  logic               par_rdy_i,
  output logic               par_dv_o,
  output logic [15:0]        par_dat_o,
  output logic               stat_ovf_o,
  output logic [31:0]        stat_frm_o,
  output logic [FIFO_AW:0]   fifo_lvl_o,
  output logic [1:0]         dbg_state
);

  // Handshake: a word moves on every edge where par_dv_o && par_rdy_i; while
  // par_dv_o is high and par_rdy_i low, par_dat_o holds; par_dv_o stays high
  // from header through trailer.
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2, TRL = 2'd3} state_t;

  localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
`ifdef DAISY_FRAMER_CRC_EN
  localparam logic [15:0] CSUM_INIT = 16'hFFFF;
`else
  localparam logic [15:0] CSUM_INIT = 16'h0000;
`endif

  state_t               state;
  logic [15:0]          mem [1 << FIFO_AW];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic                 in_dv_q;
  logic [15:0]          in_dat_q;
  logic [7:0]           len_q, len_eff, cnt, seq;
  logic [15:0]          csum, csum_nxt;
  logic                 full, flush, wr, pop, ovf_set, frm_inc, can_start;
  logic [FIFO_AW:0]     lvl_nxt;

`ifdef DAISY_FRAMER_CRC_EN
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  always_comb begin
    full      = (fifo_lvl_o == LVL_FULL);
    flush     = (state == IDLE) && !cfg_en_i;
    wr        = in_dv_q && !full && !flush;
    ovf_set   = in_dv_q && full && !flush;
    pop       = (state == PAY) && par_rdy_i;
    frm_inc   = (state == TRL) && par_rdy_i;
    rd_nxt    = rd_ptr + PTR_ONE;
    len_eff   = (cfg_len_i == 8'd0) ? 8'd1 : cfg_len_i;
    can_start = cfg_en_i && ({24'd0, len_eff} <= 32'(fifo_lvl_o));
`ifdef DAISY_FRAMER_CRC_EN
    csum_nxt  = crc16_step(csum, par_dat_o);
`else
    csum_nxt  = csum + par_dat_o;
`endif
    lvl_nxt = fifo_lvl_o;
    if (flush)            lvl_nxt = '0;
    else if (wr && !pop)  lvl_nxt = fifo_lvl_o + LVL_ONE;
    else if (!wr && pop)  lvl_nxt = fifo_lvl_o - LVL_ONE;
  end

  assign dbg_state = state;

  always_ff @(posedge par_clk_i) begin
    if (wr) mem[wr_ptr] <= in_dat_q;
  end

  // Input is staged one cycle before the FIFO write, so overflow is judged on the registered level.
  always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
    if (!par_rstn_i) begin
      in_dv_q    <= 1'b0;
      in_dat_q   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_lvl_o <= '0;
      stat_ovf_o <= 1'b0;
      stat_frm_o <= '0;
    end else begin
      in_dv_q    <= dv_i && cfg_en_i;
      in_dat_q   <= dat_i;
      fifo_lvl_o <= lvl_nxt;
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_nxt;
      if (stat_clr_i) begin
        stat_ovf_o <= 1'b0;
        stat_frm_o <= '0;
      end else begin
        if (ovf_set) stat_ovf_o <= 1'b1;
        if (frm_inc && stat_frm_o != 32'hFFFF_FFFF) stat_frm_o <= stat_frm_o + 32'd1;
      end
    end
  end

  always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
    if (!par_rstn_i) begin
      state     <= IDLE;
      par_dv_o  <= 1'b0;
      par_dat_o <= '0;
      len_q     <= 8'd1;
      cnt       <= '0;
      seq       <= '0;
      csum      <= CSUM_INIT;
    end else begin
      case (state)
        IDLE: begin
          par_dv_o <= 1'b0;
          if (can_start) begin
            len_q     <= len_eff;
            state     <= HDR;
            par_dv_o  <= 1'b1;
            par_dat_o <= {HDR_TAG, seq};
          end
        end
        HDR: begin
          if (par_rdy_i) begin
            state     <= PAY;
            cnt       <= '0;
            csum      <= CSUM_INIT;
            par_dat_o <= mem[rd_ptr];
          end
        end
        PAY: begin
          if (par_rdy_i) begin
            csum <= csum_nxt;
            cnt  <= cnt + 8'd1;
            if (cnt == len_q - 8'd1) begin
              state     <= TRL;
              par_dat_o <= csum_nxt;
            end else begin
              par_dat_o <= mem[rd_nxt];
            end
          end
        end
        TRL: begin
          if (par_rdy_i) begin
            seq <= seq + 8'd1;
            // Back-to-back frames when enough samples are already queued.
            if (can_start) begin
              len_q     <= len_eff;
              state     <= HDR;
              par_dat_o <= {HDR_TAG, seq + 8'd1};
            end else begin
              state    <= IDLE;
              par_dv_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_daisy_framer.sv
// Scoreboard bench for red_pitaya_daisy_framer: expected words queued at stimulus time, popped by a monitor.
module tb_red_pitaya_daisy_framer;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, dv, rdy;
  logic [7:0]  len;
  logic [15:0] dat;
  logic        par_dv, ovf;
  logic [15:0] par_dat;
  logic [31:0] frm;
  logic [9:0]  lvl;
  logic [1:0]  st;

  logic        en_s, clr_s, dv_s, rdy_s;
  logic [7:0]  len_s;
  logic [15:0] dat_s;
  logic        par_dv_s, ovf_s;
  logic [15:0] par_dat_s;
  logic [31:0] frm_s;
  logic [3:0]  lvl_s;
  logic [1:0]  st_s;

  logic [15:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        rnd_rdy = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_dat = '0;

  red_pitaya_daisy_framer dut (
    .par_clk_i(clk), .par_rstn_i(rst_n), .cfg_en_i(en), .cfg_len_i(len),
    .stat_clr_i(clr), .dat_i(dat), .dv_i(dv), .par_rdy_i(rdy),
    .par_dv_o(par_dv), .par_dat_o(par_dat), .stat_ovf_o(ovf),
    .stat_frm_o(frm), .fifo_lvl_o(lvl), .dbg_state(st)
  );

  red_pitaya_daisy_framer #(.FIFO_AW(3)) dut_s (
    .par_clk_i(clk), .par_rstn_i(rst_n), .cfg_en_i(en_s), .cfg_len_i(len_s),
    .stat_clr_i(clr_s), .dat_i(dat_s), .dv_i(dv_s), .par_rdy_i(rdy_s),
    .par_dv_o(par_dv_s), .par_dat_o(par_dat_s), .stat_ovf_o(ovf_s),
    .stat_frm_o(frm_s), .fifo_lvl_o(lvl_s), .dbg_state(st_s)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #2;
      rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef DAISY_FRAMER_CRC_EN
  localparam logic [15:0] ACC_INIT = 16'hFFFF;
  function automatic logic [15:0] acc(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    logic [31:0] x;
    r = c;
    for (int b = 0; b < 16; b++) begin
      x = {16'd0, r} << 1;
      if (r[15] != w[15 - b]) r = x[15:0] ^ 16'h1021;
      else                    r = x[15:0];
    end
    return r;
  endfunction
`else
  localparam logic [15:0] ACC_INIT = 16'h0000;
  function automatic logic [15:0] acc(input logic [15:0] c, input logic [15:0] w);
    return 16'(c + w);
  endfunction
`endif

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {15'd0, par_dv, par_dat}, {15'd0, 1'b1, prev_dat});
      if (par_dv && rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {16'd0, par_dat}, 32'hFFFF_FFFF);
        end else begin
          chk("out_word", {16'd0, par_dat}, {16'd0, exp_q.pop_front()});
        end
      end
      prev_stall = par_dv && !rdy;
      prev_dat   = par_dat;
    end
  end

  // driver tasks
  task automatic send(input logic [15:0] w);
    dv = 1'b1;
    dat = w;
    @(posedge clk); #1;
    dv = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] sq, input logic [15:0] w0, input int n, input int stride);
    logic [15:0] c, w;
    c = ACC_INIT;
    exp_q.push_back({8'hA5, sq});
    for (int k = 0; k < n; k++) begin
      w = 16'(w0 + k * stride);
      exp_q.push_back(w);
      c = acc(c, w);
    end
    exp_q.push_back(c);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; dv = 1'b0; rdy = 1'b1; clr = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    logic [15:0] w;
    rst_n = 1'b0; en = 1'b0; len = 8'd0; clr = 1'b0; dv = 1'b0; dat = '0; rdy = 1'b1;
    en_s = 1'b0; len_s = 8'd0; clr_s = 1'b0; dv_s = 1'b0; dat_s = '0; rdy_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", {31'd0, par_dv}, 0);
    chk("rst_dat", {16'd0, par_dat}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_frm", frm, 0);
    chk("rst_lvl", {22'd0, lvl}, 0);
    chk("rst_state", {30'd0, st}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic 4-word frame: A500 0001 0002 0003 0004 000A
    en = 1'b1; len = 8'd4;
`ifndef DAISY_FRAMER_CRC_EN
    exp_q.push_back(16'hA500); exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003); exp_q.push_back(16'h0004); exp_q.push_back(16'h000A);
`else
    push_frame(8'h00, 16'h0001, 4, 1);
`endif
    for (int i = 1; i <= 4; i++) send(16'(i));
    drain(100);
    chk("frm_after_t1", frm, 1);

    // len 0 treated as 1, plus write-to-header latency
    do_reset();
    en = 1'b1; len = 8'd0;
    push_frame(8'h00, 16'h0010, 1, 0);
    push_frame(8'h01, 16'h0020, 1, 0);
    push_frame(8'h02, 16'h0030, 1, 0);
    send(16'h0010);
    chk("lat_lvl_n0", {22'd0, lvl}, 0);
    @(posedge clk); #1;
    chk("lat_lvl_n1", {22'd0, lvl}, 1);
    chk("lat_dv_n1", {31'd0, par_dv}, 0);
    @(posedge clk); #1;
    chk("lat_hdr_n2", {15'd0, par_dv, par_dat}, {15'd0, 1'b1, 16'hA500});
    send(16'h0020);
    send(16'h0030);
    drain(100);
    chk("frm_after_t2", frm, 3);

    // 257 frames: sequence number wraps
    do_reset();
    en = 1'b1; len = 8'd1;
    for (int i = 0; i < 257; i++) push_frame(8'(i), 16'(i * 3 + 1), 1, 0);
    for (int i = 0; i < 257; i++) send(16'(i * 3 + 1));
    drain(2000);
    chk("frm_wrap", frm, 257);

    // random backpressure while streaming
    do_reset();
    en = 1'b1; len = 8'd5;
    for (int f = 0; f < 4; f++) push_frame(8'(f), 16'(f * 5 * 16'h1111 + 3), 5, 16'h1111);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 20; i++) send(16'(i * 16'h1111 + 3));
    drain(1000);
    rnd_rdy = 1'b0;
    @(posedge clk); #3;
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("frm_rnd", frm, 4);

    // small FIFO overflow and clear
    en_s = 1'b1; len_s = 8'd255; rdy_s = 1'b0;
    for (int i = 0; i < 9; i++) begin
      dv_s = 1'b1; dat_s = 16'(i);
      @(posedge clk); #1;
    end
    dv_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_lvl", {28'd0, lvl_s}, 8);
    chk("ovf_set", {31'd0, ovf_s}, 1);
    clr_s = 1'b1;
    @(posedge clk); #1;
    clr_s = 1'b0;
    chk("ovf_clr", {31'd0, ovf_s}, 0);
    chk("ovf_lvl_kept", {28'd0, lvl_s}, 8);

    // enable drops mid-payload: frame completes, leftovers flushed
    do_reset();
    en = 1'b1; len = 8'd4;
    push_frame(8'h00, 16'h0100, 4, 1);
    for (int i = 0; i < 6; i++) send(16'(16'h0100 + i));
    c = 0;
    while (!(par_dv && par_dat == 16'h0100) && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reach_pay", c < 50, 1);
    en = 1'b0;
    drain(100);
    repeat (3) @(posedge clk);
    #1;
    chk("dis_lvl", {22'd0, lvl}, 0);
    chk("dis_dv", {31'd0, par_dv}, 0);
    chk("dis_frm", frm, 1);

    // reset in the middle of a stalled frame
    en = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h0200);
    c = 0;
    while (!par_dv && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("stall_hdr", {16'd0, par_dat}, {16'd0, 16'hA501});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dv", {31'd0, par_dv}, 0);
    chk("async_rst_lvl", {22'd0, lvl}, 0);
    w = par_dat;
    chk("async_rst_dat", {16'd0, w}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; rdy = 1'b1; en = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
